// File: rtl/swapper_pkg.sv
// Shared definitions for the swap command issuer: FSM encoding and swapper sequence length.
package swapper_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ISSUE      = 2'd1,
    WAIT_START = 2'd2,
    WAIT_DONE  = 2'd3
  } swap_state_e;

  // Number of cycles the swapper holds its write strobe per sequence.
  localparam int SWAP_SEQ_LEN = 3;

endpackage

// File: rtl/swap_req_fifo.sv
// Synchronous request FIFO holding packed {addr_a, addr_b} pairs; pointers wrap naturally.
module swap_req_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             push_ok;
  logic             pop_ok;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Storage carries no reset; only the pointers and occupancy define validity.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/swap_cmd_issuer.sv
// Buffers swap requests and issues one swap pulse per request, holding the address pair for the sequence.
// Handshake: a request transfers on a rising edge where req_valid && req_ready; req_ready depends only on occupancy.
module swap_cmd_issuer
  import swapper_pkg::*;
#(
  parameter  int ADDR_W      = 4,
  parameter  int DEPTH       = 4,
  parameter  int TIMEOUT_CYC = 4,
  localparam int CNT_W       = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr_a,
  input  logic [ADDR_W-1:0] req_addr_b,
  output logic              swap,
  input  logic              busy_w,
  output logic [ADDR_W-1:0] addr_a,
  output logic [ADDR_W-1:0] addr_b,
  output logic              done,
  output logic              idle,
  output logic [CNT_W-1:0]  count,
  output logic              err,
  output swap_state_e       state_dbg
);

  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  swap_state_e         state_q;
  logic                swap_q;
  logic                err_q;
  logic [ADDR_W-1:0]   addr_a_q;
  logic [ADDR_W-1:0]   addr_b_q;
  logic [TO_W-1:0]     to_cnt_q;
  logic [TO_W-1:0]     to_cnt_d;
  logic [2*ADDR_W-1:0] head;
  logic                fifo_full;
  logic                fifo_empty;
  logic                fifo_pop;

  swap_req_fifo #(
    .WIDTH (2 * ADDR_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (req_valid),
    .wdata_i ({req_addr_a, req_addr_b}),
    .pop_i   (fifo_pop),
    .rdata_o (head),
    .count_o (count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // A new pair is only taken while the swapper is quiet, so swap cannot land on an active sequence.
  assign fifo_pop  = (state_q == IDLE) && !fifo_empty && !busy_w;
  assign to_cnt_d  = to_cnt_q + TO_W'(1);

  assign req_ready = !fifo_full;
  assign swap      = swap_q;
  assign addr_a    = addr_a_q;
  assign addr_b    = addr_b_q;
  assign err       = err_q;
  assign done      = (state_q == WAIT_DONE) && !busy_w;
  assign idle      = (state_q == IDLE) && fifo_empty;
  assign state_dbg = state_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      swap_q   <= 1'b0;
      err_q    <= 1'b0;
      addr_a_q <= '0;
      addr_b_q <= '0;
      to_cnt_q <= '0;
    end else begin
      swap_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (fifo_pop) begin
            addr_a_q <= head[2*ADDR_W-1:ADDR_W];
            addr_b_q <= head[ADDR_W-1:0];
            swap_q   <= 1'b1;
            state_q  <= ISSUE;
          end
        end
        ISSUE: begin
          to_cnt_q <= '0;
          state_q  <= WAIT_START;
        end
        WAIT_START: begin
          if (busy_w) begin
            state_q <= WAIT_DONE;
          end else if (to_cnt_d == TO_W'(TIMEOUT_CYC)) begin
            err_q   <= 1'b1;
            state_q <= IDLE;
          end else begin
            to_cnt_q <= to_cnt_d;
          end
        end
        WAIT_DONE: begin
          if (!busy_w) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_swap_cmd_issuer.sv
// Bench for swap_cmd_issuer: swapper model, per-cycle vector table, scoreboard on issued pairs, corner sequences.
module tb_swap_cmd_issuer;
  import swapper_pkg::*;

  localparam int ADDR_W      = 4;
  localparam int DEPTH       = 4;
  localparam int TIMEOUT_CYC = 4;
  localparam int CNT_W       = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              req_valid = 1'b0;
  logic [ADDR_W-1:0] req_addr_a = '0;
  logic [ADDR_W-1:0] req_addr_b = '0;
  logic              req_ready;
  logic              swap;
  logic              busy_w;
  logic [ADDR_W-1:0] addr_a;
  logic [ADDR_W-1:0] addr_b;
  logic              done;
  logic              idle;
  logic [CNT_W-1:0]  count;
  logic              err;
  swap_state_e       state_dbg;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [2*ADDR_W-1:0] exp_q[$];
  int swap_cyc_q[$];

  swap_cmd_issuer #(
    .ADDR_W(ADDR_W), .DEPTH(DEPTH), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr_a(req_addr_a), .req_addr_b(req_addr_b), .swap(swap), .busy_w(busy_w),
    .addr_a(addr_a), .addr_b(addr_b), .done(done), .idle(idle), .count(count),
    .err(err), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  // swapper model: strobe high SWAP_SEQ_LEN cycles starting the cycle after swap
  logic model_en = 1'b1;
  logic busy_hold = 1'b0;
  int   busy_cnt = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!reset_n) busy_cnt <= 0;
    else if (swap && model_en) busy_cnt <= SWAP_SEQ_LEN;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign busy_w = (busy_cnt != 0) || busy_hold;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event not seen within cycle budget (cycle %0d)", name, cyc);
  endtask

  // scoreboard + continuous properties, sampled on the falling edge
  logic [ADDR_W-1:0]   prev_a, prev_b;
  logic                prev_swap = 1'b0;
  logic [2*ADDR_W-1:0] sb_e;
  always @(negedge clk) begin
    if (!reset_n) begin
      exp_q.delete();
    end else begin
      if (req_valid && req_ready) exp_q.push_back({req_addr_a, req_addr_b});
      if (swap) begin
        swap_cyc_q.push_back(cyc);
        check("swap_while_busy", {31'd0, busy_w}, 32'd0);
        check("swap_single_pulse", {31'd0, prev_swap}, 32'd0);
        if (exp_q.size() == 0) begin
          timeout_fail("sb_unexpected_swap");
        end else begin
          sb_e = exp_q.pop_front();
          check("sb_addr_a", addr_a, sb_e[2*ADDR_W-1:ADDR_W]);
          check("sb_addr_b", addr_b, sb_e[ADDR_W-1:0]);
        end
      end
      if (busy_w) check("addr_stable_busy", {addr_a, addr_b}, {prev_a, prev_b});
    end
    prev_a    = addr_a;
    prev_b    = addr_b;
    prev_swap = swap;
  end

  // driver tasks
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b);
    req_valid  = 1'b1;
    req_addr_a = a;
    req_addr_b = b;
    next_cycle();
    req_valid = 1'b0;
  endtask

  task automatic wait_swap(input string tag);
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (swap) begin
        next_cycle();
        return;
      end
      next_cycle();
    end
    timeout_fail(tag);
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (done) begin
        next_cycle();
        return;
      end
      next_cycle();
    end
    timeout_fail(tag);
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (idle && !busy_w && exp_q.size() == 0) begin
        next_cycle();
        return;
      end
      next_cycle();
    end
    timeout_fail(tag);
  endtask

  typedef struct {
    logic              v;
    logic [ADDR_W-1:0] a;
    logic [ADDR_W-1:0] b;
    logic              e_swap;
    logic              e_done;
    logic              e_idle;
    logic [CNT_W-1:0]  e_cnt;
    logic [ADDR_W-1:0] e_a;
    logic [ADDR_W-1:0] e_b;
  } vec_t;
  vec_t tbl[9];

  initial begin
    // single request a=3,b=9 into an empty FIFO, cycle 0 is the push cycle
    tbl[0] = '{1'b1, 4'd3, 4'd9, 1'b0, 1'b0, 1'b1, 3'd0, 4'd0, 4'd0};
    tbl[1] = '{1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 3'd1, 4'd0, 4'd0};
    tbl[2] = '{1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 3'd0, 4'd3, 4'd9};
    tbl[3] = '{1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 3'd0, 4'd3, 4'd9};
    tbl[4] = '{1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 3'd0, 4'd3, 4'd9};
    tbl[5] = '{1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 3'd0, 4'd3, 4'd9};
    tbl[6] = '{1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 3'd0, 4'd3, 4'd9};
    tbl[7] = '{1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 3'd0, 4'd3, 4'd9};
    tbl[8] = '{1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 3'd0, 4'd3, 4'd9};

    // reset
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_count", count, 0);
    check("rst_swap", swap, 0);
    check("rst_done", done, 0);
    check("rst_idle", idle, 1);
    check("rst_err", err, 0);
    check("rst_ready", req_ready, 1);
    check("rst_addr", {addr_a, addr_b}, 0);
    next_cycle();
    reset_n = 1'b1;

    // single request timeline
    for (int i = 0; i < 9; i++) begin
      req_valid  = tbl[i].v;
      req_addr_a = tbl[i].a;
      req_addr_b = tbl[i].b;
      @(negedge clk);
      check($sformatf("t1_swap_c%0d", i), swap, tbl[i].e_swap);
      check($sformatf("t1_done_c%0d", i), done, tbl[i].e_done);
      check($sformatf("t1_idle_c%0d", i), idle, tbl[i].e_idle);
      check($sformatf("t1_count_c%0d", i), count, tbl[i].e_cnt);
      check($sformatf("t1_addr_c%0d", i), {addr_a, addr_b}, {tbl[i].e_a, tbl[i].e_b});
      check($sformatf("t1_ready_c%0d", i), req_ready, 1);
      next_cycle();
    end
    req_valid = 1'b0;

    // five requests with the issuer held off: the fifth waits on a full FIFO
    busy_hold = 1'b1;
    swap_cyc_q.delete();
    for (int k = 0; k < 4; k++) begin
      req_addr_a = ADDR_W'($urandom_range(0, 15));
      req_addr_b = (k == 2) ? req_addr_a : ADDR_W'($urandom_range(0, 15));
      req_valid  = 1'b1;
      @(negedge clk);
      check("t2_ready_fill", req_ready, 1);
      next_cycle();
    end
    req_addr_a = 4'd12;
    req_addr_b = 4'd5;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("t2_full_ready", req_ready, 0);
      check("t2_full_count", count, DEPTH);
      next_cycle();
    end
    busy_hold = 1'b0;
    for (int i = 0; i < 8 && req_valid; i++) begin
      @(negedge clk);
      if (req_ready) begin
        next_cycle();
        req_valid = 1'b0;
      end else begin
        next_cycle();
      end
    end
    if (req_valid) begin
      req_valid = 1'b0;
      timeout_fail("t2_fifth_accept");
    end
    for (int i = 0; i < 80 && swap_cyc_q.size() < 5; i++) next_cycle();
    wait_drain("t2_drain");
    check("t2_swap_total", swap_cyc_q.size(), 5);
    for (int k = 1; k < 5 && k < swap_cyc_q.size(); k++)
      check($sformatf("t2_swap_spacing_%0d", k), swap_cyc_q[k] - swap_cyc_q[k-1], 6);
    check("t2_idle", idle, 1);

    // push and pop on the same edge with two entries queued
    push_one(4'd1, 4'd2);
    wait_swap("t3_swap_a");
    push_one(4'd4, 4'd6);
    push_one(4'd7, 4'd8);
    wait_done("t3_done_a");
    req_valid  = 1'b1;
    req_addr_a = 4'd10;
    req_addr_b = 4'd11;
    @(negedge clk);
    check("t3_count_before", count, 2);
    check("t3_state_idle", state_dbg, IDLE);
    next_cycle();
    req_valid = 1'b0;
    @(negedge clk);
    check("t3_count_after", count, 2);
    check("t3_swap_b", swap, 1);
    next_cycle();
    wait_drain("t3_drain");

    // swapper never responds: timeout raises sticky err
    model_en = 1'b0;
    push_one(4'd13, 4'd14);
    wait_swap("t4_swap");
    for (int j = 1; j <= 5; j++) begin
      @(negedge clk);
      if (j == 4) check("t4_err_early", err, 0);
      if (j == 5) begin
        check("t4_err_set", err, 1);
        check("t4_idle", idle, 1);
        check("t4_state", state_dbg, IDLE);
      end
      next_cycle();
    end
    model_en = 1'b1;
    push_one(4'd2, 4'd2);
    push_one(4'd15, 4'd0);
    wait_drain("t4_drain");
    check("t4_err_sticky", err, 1);

    // reset in WAIT_DONE with three requests queued
    push_one(4'd5, 4'd6);
    wait_swap("t5_swap");
    push_one(4'd1, 4'd1);
    push_one(4'd2, 4'd3);
    push_one(4'd4, 4'd5);
    reset_n = 1'b0;
    @(negedge clk);
    check("t5_pre_state", state_dbg, WAIT_DONE);
    check("t5_pre_count", count, 3);
    next_cycle();
    reset_n = 1'b1;
    @(negedge clk);
    check("t5_count", count, 0);
    check("t5_swap", swap, 0);
    check("t5_addr", {addr_a, addr_b}, 0);
    check("t5_idle", idle, 1);
    check("t5_err", err, 0);
    check("t5_done", done, 0);
    next_cycle();
    repeat (3) begin
      @(negedge clk);
      check("t5_no_swap", swap, 0);
      next_cycle();
    end
    push_one(4'd9, 4'd3);
    wait_drain("t5_recover");
    check("t5_recover_addr", {addr_a, addr_b}, {4'd9, 4'd3});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
